// File: rtl/cpu_types_pkg.sv
// Shared types for the cache-to-RAM arbiter: arbiter states, RAM status
// encoding and the machine word.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    RAM_FREE   = 2'd0,
    RAM_BUSY   = 2'd1,
    RAM_ACCESS = 2'd2,
    RAM_ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational one-hot pick of the first set request bit strictly after
// ptr, wrapping modulo N.
module rr_picker #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  int   idx;
  logic found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int off = 1; off <= N; off++) begin
      idx = (int'(ptr) + off) % N;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter for CPUS icaches and CPUS dcaches; holds the grant
// across block transfers. Define MEM_ARBITER_RR_EN for round-robin core ties.
//
// state | meaning
// IDLE  | no owner, strobes low, pick next requester
// OWN   | owner drives RAM, everyone else waits
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int CPUS    = 2,
  parameter int MAXHOLD = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [CPUS-1:0]      iREN,
  input  logic [CPUS*32-1:0]   iaddr,
  output logic [CPUS*32-1:0]   iload,
  output logic [CPUS-1:0]      iwait,
  input  logic [CPUS-1:0]      dREN,
  input  logic [CPUS-1:0]      dWEN,
  input  logic [CPUS*32-1:0]   daddr,
  input  logic [CPUS*32-1:0]   dstore,
  output logic [CPUS*32-1:0]   dload,
  output logic [CPUS-1:0]      dwait,
  output logic                 ramREN,
  output logic                 ramWEN,
  output logic [31:0]          ramaddr,
  output logic [31:0]          ramstore,
  input  logic [31:0]          ramload,
  input  logic [1:0]           ramstate
);

  localparam int CW = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam int HW = $clog2(MAXHOLD + 1);

  arb_state_t      state_q, state_d;
  logic            owner_is_d_q, owner_is_d_d;
  logic [CW-1:0]   owner_core_q, owner_core_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [CW-1:0]   ptr;

  logic [CPUS-1:0] wen_oh, ren_oh, i_oh, sel_oh;
  logic            sel_is_d;
  logic [CW-1:0]   sel_idx;
  logic            owner_req;
  logic            access;
  word_t           owner_addr, owner_store;

`ifdef MEM_ARBITER_RR_EN
  logic [CW-1:0]   last_q, last_d;
  assign ptr = last_q;
`else
  // Pointer parked on the top core so the picker always favours core 0.
  assign ptr = CW'(CPUS - 1);
`endif

  rr_picker #(.N(CPUS), .PW(CW)) u_pick_wen (.req(dWEN), .ptr(ptr), .gnt(wen_oh));
  rr_picker #(.N(CPUS), .PW(CW)) u_pick_ren (.req(dREN), .ptr(ptr), .gnt(ren_oh));
  rr_picker #(.N(CPUS), .PW(CW)) u_pick_i   (.req(iREN), .ptr(ptr), .gnt(i_oh));

  assign iload  = {CPUS{ramload}};
  assign dload  = {CPUS{ramload}};
  assign access = (ramstate_t'(ramstate) == RAM_ACCESS);

  always_comb begin
    state_d      = state_q;
    owner_is_d_d = owner_is_d_q;
    owner_core_d = owner_core_q;
    hold_d       = hold_q;
`ifdef MEM_ARBITER_RR_EN
    last_d       = last_q;
`endif
    iwait        = '1;
    dwait        = '1;
    ramREN       = 1'b0;
    ramWEN       = 1'b0;
    ramaddr      = '0;
    ramstore     = '0;
    sel_oh       = '0;
    sel_is_d     = 1'b0;
    sel_idx      = '0;
    owner_req    = 1'b0;
    owner_addr   = '0;
    owner_store  = '0;

    case (state_q)
      IDLE: begin
        if (|dWEN) begin
          sel_oh   = wen_oh;
          sel_is_d = 1'b1;
        end else if (|dREN) begin
          sel_oh   = ren_oh;
          sel_is_d = 1'b1;
        end else if (|iREN) begin
          sel_oh   = i_oh;
        end
        for (int i = 0; i < CPUS; i++) begin
          if (sel_oh[i]) sel_idx = CW'(i);
        end
        if (|sel_oh) begin
          state_d      = OWN;
          owner_is_d_d = sel_is_d;
          owner_core_d = sel_idx;
          hold_d       = '0;
        end
      end

      OWN: begin
        if (owner_is_d_q) begin
          owner_addr                = daddr[int'(owner_core_q)*32 +: 32];
          owner_store               = dstore[int'(owner_core_q)*32 +: 32];
          ramREN                    = dREN[owner_core_q];
          ramWEN                    = dWEN[owner_core_q];
          ramstore                  = owner_store;
          dwait[owner_core_q]       = ~access;
          owner_req                 = dREN[owner_core_q] | dWEN[owner_core_q];
        end else begin
          owner_addr                = iaddr[int'(owner_core_q)*32 +: 32];
          ramREN                    = iREN[owner_core_q];
          iwait[owner_core_q]       = ~access;
          owner_req                 = iREN[owner_core_q];
        end
        ramaddr = owner_addr;

        if (access) hold_d = hold_q + 1'b1;

        if (!owner_req || (access && hold_q == HW'(MAXHOLD - 1))) begin
          state_d = IDLE;
          hold_d  = '0;
`ifdef MEM_ARBITER_RR_EN
          last_d  = owner_core_q;
`endif
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      owner_is_d_q <= 1'b0;
      owner_core_q <= '0;
      hold_q       <= '0;
`ifdef MEM_ARBITER_RR_EN
      last_q       <= CW'(CPUS - 1);
`endif
    end else begin
      state_q      <= state_d;
      owner_is_d_q <= owner_is_d_d;
      owner_core_q <= owner_core_d;
      hold_q       <= hold_d;
`ifdef MEM_ARBITER_RR_EN
      last_q       <= last_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (CPUS=2, MAXHOLD=4); the
// round-robin expectations follow MEM_ARBITER_RR_EN.
module tb_mem_arbiter;

  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  logic        clk_sys = 1'b0;
  logic        RST;
  logic [1:0]  iREN, dREN, dWEN;
  logic [63:0] iaddr, daddr, dstore;
  logic [63:0] iload, dload;
  logic [1:0]  iwait, dwait;
  logic        ramREN, ramWEN;
  logic [31:0] ramaddr, ramstore, ramload;
  logic [1:0]  ramstate;

  int tests  = 0;
  int errors = 0;

  always #5 clk_sys = ~clk_sys;

  mem_arbiter #(.CPUS(2), .MAXHOLD(4)) dut (
    .CLK(clk_sys), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dwait(dwait),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here.
  task automatic cyc();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    iREN = '0; dREN = '0; dWEN = '0;
    iaddr = '0; daddr = '0; dstore = '0;
    ramload = '0; ramstate = FREE;
  endtask

  int exp_core;
  logic [31:0] exp_addr;

  initial begin
    RST = 1'b1;
    clear_inputs();
    cyc(); cyc();
    settle();
    check_eq("rst_iwait", {30'd0, iwait}, 32'h3);
    check_eq("rst_dwait", {30'd0, dwait}, 32'h3);
    check_eq("rst_ramREN", {31'd0, ramREN}, 32'h0);
    check_eq("rst_ramWEN", {31'd0, ramWEN}, 32'h0);
    check_eq("rst_ramaddr", ramaddr, 32'h0);
    check_eq("rst_ramstore", ramstore, 32'h0);

    // single icache read
    cyc(); RST = 1'b0;
    iREN = 2'b01; iaddr[31:0] = 32'h40;
    settle();
    check_eq("ird_c1_ramREN", {31'd0, ramREN}, 32'h0);
    check_eq("ird_c1_iwait0", {31'd0, iwait[0]}, 32'h1);
    cyc(); ramstate = ACCESS; ramload = 32'hDEADBEEF;
    settle();
    check_eq("ird_c2_ramREN", {31'd0, ramREN}, 32'h1);
    check_eq("ird_c2_ramaddr", ramaddr, 32'h40);
    check_eq("ird_c2_iwait0", {31'd0, iwait[0]}, 32'h0);
    check_eq("ird_c2_iload0", iload[31:0], 32'hDEADBEEF);
    check_eq("ird_c2_iwait1", {31'd0, iwait[1]}, 32'h1);
    cyc(); iREN = 2'b00; ramstate = FREE;
    settle();
    check_eq("ird_c3_ramREN", {31'd0, ramREN}, 32'h0);
    cyc();
    settle();
    check_eq("ird_c4_iwait", {30'd0, iwait}, 32'h3);

    // priority: dWEN[1] beats iREN[0]
    cyc(); iREN = 2'b01; iaddr[31:0] = 32'h40;
    dWEN = 2'b10; daddr[63:32] = 32'h200; dstore[63:32] = 32'h1234;
    settle();
    check_eq("pri_a_ramWEN", {31'd0, ramWEN}, 32'h0);
    cyc();
    settle();
    check_eq("pri_b_ramWEN", {31'd0, ramWEN}, 32'h1);
    check_eq("pri_b_ramREN", {31'd0, ramREN}, 32'h0);
    check_eq("pri_b_ramaddr", ramaddr, 32'h200);
    check_eq("pri_b_ramstore", ramstore, 32'h1234);
    check_eq("pri_b_iwait0", {31'd0, iwait[0]}, 32'h1);
    check_eq("pri_b_dwait1", {31'd0, dwait[1]}, 32'h1);
    cyc(); ramstate = ACCESS;
    settle();
    check_eq("pri_c_dwait1", {31'd0, dwait[1]}, 32'h0);
    check_eq("pri_c_iwait0", {31'd0, iwait[0]}, 32'h1);
    cyc(); dWEN = 2'b00; ramstate = FREE;
    settle();
    check_eq("pri_d_iwait0", {31'd0, iwait[0]}, 32'h1);
    check_eq("pri_d_ramWEN", {31'd0, ramWEN}, 32'h0);
    cyc();
    settle();
    check_eq("pri_bubble_ramREN", {31'd0, ramREN}, 32'h0);
    check_eq("pri_bubble_iwait0", {31'd0, iwait[0]}, 32'h1);
    cyc(); ramstate = ACCESS;
    settle();
    check_eq("pri_f_ramREN", {31'd0, ramREN}, 32'h1);
    check_eq("pri_f_ramaddr", ramaddr, 32'h40);
    check_eq("pri_f_iwait0", {31'd0, iwait[0]}, 32'h0);
    cyc(); iREN = 2'b00; ramstate = FREE;
    cyc();

    // block hold: dcache0 two words, icache1 competing, one ERROR cycle
    cyc(); dREN = 2'b01; daddr[31:0] = 32'h100; iREN = 2'b10; iaddr[63:32] = 32'h300;
    settle();
    check_eq("blk_idle_ramREN", {31'd0, ramREN}, 32'h0);
    cyc(); ramstate = BUSY;
    settle();
    check_eq("blk_w0_busy_ramaddr", ramaddr, 32'h100);
    check_eq("blk_w0_busy_dwait0", {31'd0, dwait[0]}, 32'h1);
    cyc(); ramstate = ERROR;
    settle();
    check_eq("blk_w0_err_dwait0", {31'd0, dwait[0]}, 32'h1);
    check_eq("blk_w0_err_ramREN", {31'd0, ramREN}, 32'h1);
    cyc(); ramstate = ACCESS; ramload = 32'h0000AAAA;
    settle();
    check_eq("blk_w0_acc_dwait0", {31'd0, dwait[0]}, 32'h0);
    check_eq("blk_w0_acc_dload0", dload[31:0], 32'h0000AAAA);
    check_eq("blk_w0_iwait1", {31'd0, iwait[1]}, 32'h1);
    cyc(); daddr[31:0] = 32'h104; ramstate = BUSY;
    settle();
    check_eq("blk_w1_busy_ramaddr", ramaddr, 32'h104);
    check_eq("blk_w1_busy_ramREN", {31'd0, ramREN}, 32'h1);
    cyc();
    settle();
    check_eq("blk_w1_busy2_ramaddr", ramaddr, 32'h104);
    cyc(); ramstate = ACCESS; ramload = 32'h0000BBBB;
    settle();
    check_eq("blk_w1_acc_dwait0", {31'd0, dwait[0]}, 32'h0);
    check_eq("blk_w1_acc_ramaddr", ramaddr, 32'h104);
    check_eq("blk_w1_iwait1", {31'd0, iwait[1]}, 32'h1);
    cyc(); dREN = 2'b00; ramstate = FREE;
    settle();
    check_eq("blk_drop_ramREN", {31'd0, ramREN}, 32'h0);
    cyc();
    settle();
    check_eq("blk_bubble_ramREN", {31'd0, ramREN}, 32'h0);
    cyc(); ramstate = ACCESS;
    settle();
    check_eq("blk_next_ramaddr", ramaddr, 32'h300);
    check_eq("blk_next_iwait1", {31'd0, iwait[1]}, 32'h0);
    cyc(); iREN = 2'b00; ramstate = FREE;
    cyc();

    // reset while owning
    cyc(); dREN = 2'b01; daddr[31:0] = 32'h700;
    cyc();
    settle();
    check_eq("rst_own_ramREN", {31'd0, ramREN}, 32'h1);
    check_eq("rst_own_ramaddr", ramaddr, 32'h700);
    RST = 1'b1;
    cyc();
    settle();
    check_eq("rst_after_dwait", {30'd0, dwait}, 32'h3);
    check_eq("rst_after_iwait", {30'd0, iwait}, 32'h3);
    check_eq("rst_after_ramREN", {31'd0, ramREN}, 32'h0);
    check_eq("rst_after_ramaddr", ramaddr, 32'h0);
    cyc(); RST = 1'b0; clear_inputs();
    cyc();

    // MAXHOLD release and core ordering, RAM always ACCESS
    cyc(); dREN = 2'b11; daddr[31:0] = 32'h500; daddr[63:32] = 32'h600; ramstate = ACCESS;
    settle();
    check_eq("hold_idle_ramREN", {31'd0, ramREN}, 32'h0);
    for (int g = 0; g < 3; g++) begin
`ifdef MEM_ARBITER_RR_EN
      exp_core = g % 2;
`else
      exp_core = 0;
`endif
      exp_addr = (exp_core == 0) ? 32'h500 : 32'h600;
      for (int k = 0; k < 4; k++) begin
        cyc();
        settle();
        check_eq($sformatf("hold_g%0d_k%0d_ramaddr", g, k), ramaddr, exp_addr);
        check_eq($sformatf("hold_g%0d_k%0d_dwait", g, k), {30'd0, dwait},
                 (exp_core == 0) ? 32'h2 : 32'h1);
      end
      cyc();
      settle();
      check_eq($sformatf("hold_g%0d_bubble_ramREN", g), {31'd0, ramREN}, 32'h0);
      check_eq($sformatf("hold_g%0d_bubble_dwait", g), {30'd0, dwait}, 32'h3);
    end
    clear_inputs();
    cyc(); cyc();

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
